thymesisflow_credit_pool: RTL and testbench

Multi-channel successor to the single-counter credit manager. Keeps one credit counter per virtual channel for a TLX/AFU backpressure interface. Each channel has:
- an explicit uninitialised/active state,
- a configurable ceiling with saturation,
- sticky overflow/underflow errors with clear,
- a registered drain report for get-all operations,
- a low-watermark flag.

It sits between the credit-return decode logic and the per-channel command schedulers.

---
 rtl/thymesisflow_credit_pool.sv | 133 +++++++++++++
 tb/tb_thymesisflow_credit_pool.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/thymesisflow_credit_pool.sv
// Per-virtual-channel credit pool for the TLX/AFU backpressure interface.
// Each channel: UNINIT/ACTIVE state, saturating counter, sticky errors, drain report.
module thymesisflow_credit_pool #(
  parameter int NCH         = 4,
  parameter int MSB         = 5,
  parameter int RMSB        = 3,
  parameter int MAX_CREDITS = 63
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic [NCH-1:0]            reset_counter,
  input  logic [NCH*(MSB+1)-1:0]    initial_credits,
  input  logic [NCH*(RMSB+1)-1:0]   returned_credits,
  input  logic [NCH-1:0]            consume_credit,
  input  logic [NCH-1:0]            get_all_credits,
  input  logic [MSB:0]              low_watermark,
  input  logic                      err_clear,
  output logic [NCH*(MSB+1)-1:0]    credits_available,
  output logic [NCH-1:0]            channel_active,
  output logic [NCH-1:0]            credit_low,
  output logic [NCH-1:0]            drain_valid,
  output logic [NCH*(MSB+1)-1:0]    drain_count,
  output logic [NCH-1:0]            credit_overflow,
  output logic [NCH-1:0]            credit_underflow
);

  localparam int CW = MSB + 1;
  localparam int RW = RMSB + 1;
  localparam logic [CW:0] MAX_X = (CW+1)'(MAX_CREDITS);

  logic [CW-1:0]  cnt_q  [NCH];
  logic [CW-1:0]  cnt_d  [NCH];
  logic [CW-1:0]  dcnt_q [NCH];
  logic [CW-1:0]  dcnt_d [NCH];
  logic [NCH-1:0] act_q, act_d;
  logic [NCH-1:0] dv_q, dv_d;
  logic [NCH-1:0] ovf_q, ovf_d;
  logic [NCH-1:0] udf_q, udf_d;
  logic [NCH-1:0] ovf_ev, udf_ev;

  logic [CW:0] init_x [NCH];
  logic [CW:0] ret_x  [NCH];
  logic [CW:0] sum_x  [NCH];
  logic [CW:0] nxt_x  [NCH];

  always_comb begin
    act_d  = act_q;
    dv_d   = '0;
    ovf_ev = '0;
    udf_ev = '0;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i]  = cnt_q[i];
      dcnt_d[i] = dcnt_q[i];
      init_x[i] = {1'b0, initial_credits[i*CW +: CW]};
      ret_x[i]  = (CW+1)'(returned_credits[i*RW +: RW]);
      sum_x[i]  = {1'b0, cnt_q[i]} + ret_x[i];
      nxt_x[i]  = sum_x[i] - (CW+1)'(consume_credit[i]);

      if (reset_counter[i]) begin
        act_d[i] = 1'b1;
        if (init_x[i] > MAX_X) begin
          cnt_d[i]  = MAX_X[CW-1:0];
          ovf_ev[i] = 1'b1;
        end else begin
          cnt_d[i] = init_x[i][CW-1:0];
        end
      end else if (get_all_credits[i]) begin
        dv_d[i] = 1'b1;
        if (act_q[i]) begin
          dcnt_d[i] = cnt_q[i];
          cnt_d[i]  = (ret_x[i] > MAX_X) ? MAX_X[CW-1:0] : ret_x[i][CW-1:0];
        end else begin
          dcnt_d[i] = '0;
        end
      end else if (act_q[i]) begin
        // Same-cycle returns are usable by a same-cycle consume.
        if (consume_credit[i] && (sum_x[i] == '0)) begin
          udf_ev[i] = 1'b1;
          cnt_d[i]  = '0;
        end else if (nxt_x[i] > MAX_X) begin
          cnt_d[i]  = MAX_X[CW-1:0];
          ovf_ev[i] = 1'b1;
        end else begin
          cnt_d[i] = nxt_x[i][CW-1:0];
        end
      end else begin
        udf_ev[i] = consume_credit[i];
      end
    end
    // A fresh error event outranks a simultaneous clear.
    ovf_d = (ovf_q & {NCH{~err_clear}}) | ovf_ev;
    udf_d = (udf_q & {NCH{~err_clear}}) | udf_ev;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      act_q <= '0;
      dv_q  <= '0;
      ovf_q <= '0;
      udf_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]  <= '0;
        dcnt_q[i] <= '0;
      end
    end else begin
      act_q <= act_d;
      dv_q  <= dv_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]  <= cnt_d[i];
        dcnt_q[i] <= dcnt_d[i];
      end
    end
  end

  always_comb begin
    credits_available = '0;
    drain_count       = '0;
    credit_low        = '0;
    for (int i = 0; i < NCH; i++) begin
      credits_available[i*CW +: CW] = cnt_q[i];
      drain_count[i*CW +: CW]       = dcnt_q[i];
      credit_low[i]                 = act_q[i] && (cnt_q[i] <= low_watermark);
    end
  end

  assign channel_active   = act_q;
  assign drain_valid      = dv_q;
  assign credit_overflow  = ovf_q;
  assign credit_underflow = udf_q;

endmodule

// File: tb/tb_thymesisflow_credit_pool.sv
// Directed scoreboard bench for thymesisflow_credit_pool (NCH=4, CW=6, RW=4, MAX=63).
module tb_thymesisflow_credit_pool;

  localparam int NCH = 4;
  localparam int CW  = 6;
  localparam int RW  = 4;

  logic                clock = 1'b0;
  logic                resetn;
  logic [NCH-1:0]      reset_counter;
  logic [NCH*CW-1:0]   initial_credits;
  logic [NCH*RW-1:0]   returned_credits;
  logic [NCH-1:0]      consume_credit;
  logic [NCH-1:0]      get_all_credits;
  logic [CW-1:0]       low_watermark;
  logic                err_clear;
  logic [NCH*CW-1:0]   credits_available;
  logic [NCH-1:0]      channel_active;
  logic [NCH-1:0]      credit_low;
  logic [NCH-1:0]      drain_valid;
  logic [NCH*CW-1:0]   drain_count;
  logic [NCH-1:0]      credit_overflow;
  logic [NCH-1:0]      credit_underflow;

  thymesisflow_credit_pool #(.NCH(4), .MSB(5), .RMSB(3), .MAX_CREDITS(63)) dut (
    .clock(clock), .resetn(resetn), .reset_counter(reset_counter),
    .initial_credits(initial_credits), .returned_credits(returned_credits),
    .consume_credit(consume_credit), .get_all_credits(get_all_credits),
    .low_watermark(low_watermark), .err_clear(err_clear),
    .credits_available(credits_available), .channel_active(channel_active),
    .credit_low(credit_low), .drain_valid(drain_valid), .drain_count(drain_count),
    .credit_overflow(credit_overflow), .credit_underflow(credit_underflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    int                due;
    logic [NCH*CW-1:0] cnt;
    logic [NCH-1:0]    act;
    logic [NCH-1:0]    low;
    logic [NCH-1:0]    dv;
    logic [NCH*CW-1:0] dcnt;
    logic [NCH-1:0]    ovf;
    logic [NCH-1:0]    udf;
  } snap_t;

  typedef struct {
    int          ch;
    logic [CW-1:0] count;
  } drain_t;

  snap_t  sq[$];
  drain_t dq[$];
  int     checks   = 0;
  int     failures = 0;
  int     cyc      = 0;

  // hand-computed expected state, edited step by step
  int             ecnt [NCH];
  int             edc  [NCH];
  logic [NCH-1:0] eact, eovf, eudf;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (resetn) begin
      while (sq.size() > 0 && sq[0].due <= cyc) begin
        snap_t s;
        s = sq.pop_front();
        chk("credits_available", 32'(credits_available), 32'(s.cnt));
        chk("channel_active", 32'(channel_active), 32'(s.act));
        chk("credit_low", 32'(credit_low), 32'(s.low));
        chk("drain_valid", 32'(drain_valid), 32'(s.dv));
        chk("drain_count", 32'(drain_count), 32'(s.dcnt));
        chk("credit_overflow", 32'(credit_overflow), 32'(s.ovf));
        chk("credit_underflow", 32'(credit_underflow), 32'(s.udf));
      end
      for (int c = 0; c < NCH; c++) begin
        if (drain_valid[c]) begin
          if (dq.size() == 0) begin
            chk("drain_unexpected", 32'(c), 32'hFFFF_FFFF);
          end else begin
            drain_t d;
            d = dq.pop_front();
            chk("drain_channel", 32'(c), 32'(d.ch));
            chk("drain_report", 32'(drain_count[c*CW +: CW]), 32'(d.count));
          end
        end
      end
    end
  end

  task automatic clear_inputs();
    reset_counter    = '0;
    initial_credits  = '0;
    returned_credits = '0;
    consume_credit   = '0;
    get_all_credits  = '0;
    err_clear        = 1'b0;
  endtask

  task automatic clear_model();
    for (int c = 0; c < NCH; c++) begin
      ecnt[c] = 0;
      edc[c]  = 0;
    end
    eact = '0; eovf = '0; eudf = '0;
  endtask

  task automatic set_init(input int ch, input int v);
    initial_credits[ch*CW +: CW] = CW'(v);
    reset_counter[ch] = 1'b1;
  endtask

  task automatic set_ret(input int ch, input int v);
    returned_credits[ch*RW +: RW] = RW'(v);
  endtask

  task automatic expect_drain(input int ch, input int v);
    drain_t d;
    d.ch = ch;
    d.count = CW'(v);
    dq.push_back(d);
    get_all_credits[ch] = 1'b1;
    edc[ch] = v;
  endtask

  // Push the expectation for the cycle after these inputs, then apply them.
  task automatic tick();
    snap_t s;
    s.due = cyc + 1;
    s.act = eact; s.ovf = eovf; s.udf = eudf;
    s.dv  = get_all_credits;
    for (int c = 0; c < NCH; c++) begin
      s.cnt[c*CW +: CW]  = CW'(ecnt[c]);
      s.dcnt[c*CW +: CW] = CW'(edc[c]);
      s.low[c] = eact[c] && (ecnt[c] <= int'(low_watermark));
    end
    sq.push_back(s);
    @(posedge clock);
    #1;
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    clear_model();
    low_watermark = 6'd2;
    resetn = 1'b0;
    #1;
    chk("rst_cnt", 32'(credits_available), 0);
    chk("rst_act", 32'(channel_active), 0);
    chk("rst_low", 32'(credit_low), 0);
    chk("rst_dv", 32'(drain_valid), 0);
    chk("rst_dcnt", 32'(drain_count), 0);
    chk("rst_ovf", 32'(credit_overflow), 0);
    chk("rst_udf", 32'(credit_underflow), 0);
    #21 resetn = 1'b1;
    @(posedge clock); #1;

    // ch0 init 10
    set_init(0, 10); ecnt[0] = 10; eact[0] = 1; tick();
    // ch0 reload 0, then return+consume at 0, then bare consume, then clear
    set_init(0, 0); ecnt[0] = 0; tick();
    set_ret(0, 1); consume_credit[0] = 1; tick();
    consume_credit[0] = 1; eudf[0] = 1; tick();
    err_clear = 1; eudf[0] = 0; tick();
    // watermark boundary
    set_init(0, 2); ecnt[0] = 2; tick();
    set_ret(0, 1); ecnt[0] = 3; tick();
    // ch1 overflow; clear loses to a new event
    set_init(1, 60); ecnt[1] = 60; eact[1] = 1; tick();
    set_ret(1, 5); ecnt[1] = 63; eovf[1] = 1; tick();
    err_clear = 1; set_ret(1, 1); tick();
    err_clear = 1; eovf[1] = 0; tick();
    // ch2 drain with return and ignored consume, then back-to-back drain, then hold
    set_init(2, 17); ecnt[2] = 17; eact[2] = 1; tick();
    expect_drain(2, 17); set_ret(2, 3); consume_credit[2] = 1; ecnt[2] = 3; tick();
    expect_drain(2, 3); ecnt[2] = 0; tick();
    tick();
    // ch3 UNINIT: returns discarded, consume underflows, drain reports 0
    set_ret(3, 4); tick();
    consume_credit[3] = 1; eudf[3] = 1; tick();
    expect_drain(3, 0); consume_credit[3] = 1; tick();
    // ch0 normal accounting to 40
    set_init(0, 40); ecnt[0] = 40; tick();
    consume_credit[0] = 1; ecnt[0] = 39; tick();
    set_ret(0, 2); consume_credit[0] = 1; ecnt[0] = 40; tick();
    // drain ch1 (63) then async reset while drain_valid is high
    expect_drain(1, 63); ecnt[1] = 0; tick();
    @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_cnt", 32'(credits_available), 0);
    chk("mid_rst_act", 32'(channel_active), 0);
    chk("mid_rst_low", 32'(credit_low), 0);
    chk("mid_rst_dv", 32'(drain_valid), 0);
    chk("mid_rst_dcnt", 32'(drain_count), 0);
    chk("mid_rst_ovf", 32'(credit_overflow), 0);
    chk("mid_rst_udf", 32'(credit_underflow), 0);
    @(negedge clock);
    #1 resetn = 1'b1;
    clear_model();
    @(posedge clock); #1;
    set_ret(0, 4); consume_credit[1] = 1; eudf[1] = 1; tick();
    set_init(0, 5); ecnt[0] = 5; eact[0] = 1; tick();

    for (int k = 0; k < 20 && (sq.size() > 0 || dq.size() > 0); k++) @(posedge clock);
    @(negedge clock); #1;
    chk("state_queue_empty", 32'(sq.size()), 0);
    chk("drain_queue_empty", 32'(dq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
